// File: rtl/rtc_time_counter_if.sv
// Bus bundle for rtc_time_counter: seconds input, run control, load handshake and time outputs.
// The alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_time_counter_if;
    logic       usr_clk;
    logic       run;
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_err;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       sec_tick;
    logic       day_wrap;
`ifdef RTC_ALARM_EN
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_arm;
    logic       alarm;
`endif

    modport master (
        output usr_clk, run, set_valid, set_hour, set_min, set_sec,
`ifdef RTC_ALARM_EN
        output alarm_hour, alarm_min, alarm_arm,
        input  alarm,
`endif
        input  set_ready, set_err, hour, min, sec, sec_tick, day_wrap
    );

    modport slave (
        input  usr_clk, run, set_valid, set_hour, set_min, set_sec,
`ifdef RTC_ALARM_EN
        input  alarm_hour, alarm_min, alarm_arm,
        output alarm,
`endif
        output set_ready, set_err, hour, min, sec, sec_tick, day_wrap
    );
endinterface

// File: rtl/rtc_time_counter.sv
// hh:mm:ss wall clock advanced by rising edges of a synchronised 1 Hz usr_clk, with load handshake.
// Optional alarm comparator is compiled in when RTC_ALARM_EN is defined.
module rtc_time_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MAX    = 23
) (
    input logic                clk,
    input logic                reset,
    rtc_time_counter_if.slave  bus
);
    typedef enum logic [1:0] {STOP, RUN, LOAD} state_t;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    localparam logic [4:0] HOUR_LIM = 5'(HOUR_MAX);

    function automatic logic is_day_end(input hms_t t);
        return (t.hour == HOUR_LIM) && (t.min == 6'd59) && (t.sec == 6'd59);
    endfunction

    function automatic hms_t advance(input hms_t t);
        hms_t r;
        r = t;
        if (t.sec == 6'd59) begin
            r.sec = 6'd0;
            if (t.min == 6'd59) begin
                r.min  = 6'd0;
                r.hour = (t.hour == HOUR_LIM) ? 5'd0 : t.hour + 5'd1;
            end else begin
                r.min = t.min + 6'd1;
            end
        end else begin
            r.sec = t.sec + 6'd1;
        end
        return r;
    endfunction

    function automatic logic in_range(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        return (h <= HOUR_LIM) && (m <= 6'd59) && (s <= 6'd59);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   sync_out;
    logic                   edge_det;

    state_t state;
    state_t state_nxt;
    hms_t   now_q;
    hms_t   now_adv;
    logic   set_ready_q;
    logic   set_err_q;
    logic   sec_tick_q;
    logic   day_wrap_q;
    logic   xfer;
    logic   load_go;
    logic   adv;
    logic   err;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_out & ~sync_prev;
    assign xfer     = bus.set_valid & set_ready_q;
    assign now_adv  = advance(now_q);

    // An edge seen during the LOAD cycle is applied on the transition into RUN,
    // so it shows up in the first RUN cycle; exiting to STOP simply drops it.
    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        load_go   = 1'b0;
        err       = 1'b0;
        case (state)
            STOP: if (bus.run) state_nxt = RUN;
            RUN: begin
                adv = edge_det;
                if (!bus.run) state_nxt = STOP;
            end
            LOAD: begin
                adv       = bus.run & edge_det;
                state_nxt = bus.run ? RUN : STOP;
            end
            default: state_nxt = STOP;
        endcase
        if (xfer) begin
            if (in_range(bus.set_hour, bus.set_min, bus.set_sec)) begin
                load_go   = 1'b1;
                adv       = 1'b0;
                state_nxt = LOAD;
            end else begin
                err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q      <= '0;
            sync_prev   <= 1'b0;
            state       <= STOP;
            now_q       <= '0;
            set_ready_q <= 1'b0;
            set_err_q   <= 1'b0;
            sec_tick_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.usr_clk};
            sync_prev   <= sync_out;
            state       <= state_nxt;
            set_ready_q <= (state_nxt != LOAD);
            set_err_q   <= err;
            sec_tick_q  <= adv;
            day_wrap_q  <= adv & is_day_end(now_q);
            if (load_go) begin
                now_q <= '{hour: bus.set_hour, min: bus.set_min, sec: bus.set_sec};
            end else if (adv) begin
                now_q <= now_adv;
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic alarm_q;
    logic alarm_hit;

    assign alarm_hit = adv && (now_adv.hour == bus.alarm_hour) &&
                       (now_adv.min == bus.alarm_min) && (now_adv.sec == 6'd0);

    // Sticky until disarmed; loads deliberately leave it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alarm_q <= 1'b0;
        end else if (!bus.alarm_arm) begin
            alarm_q <= 1'b0;
        end else if (alarm_hit) begin
            alarm_q <= 1'b1;
        end
    end

    assign bus.alarm = alarm_q;
`endif

    assign bus.set_ready = set_ready_q;
    assign bus.set_err   = set_err_q;
    assign bus.hour      = now_q.hour;
    assign bus.min       = now_q.min;
    assign bus.sec       = now_q.sec;
    assign bus.sec_tick  = sec_tick_q;
    assign bus.day_wrap  = day_wrap_q;
endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter (SYNC_STAGES=2, HOUR_MAX=23); alarm steps need RTC_ALARM_EN.
module tb_rtc_time_counter;
    logic clk;
    logic reset;
    int   checks;
    int   passes;

    rtc_time_counter_if bus();

    rtc_time_counter #(.SYNC_STAGES(2), .HOUR_MAX(23)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hour"}, 32'(bus.hour), 32'(h));
        chk({tag, ".min"},  32'(bus.min),  32'(m));
        chk({tag, ".sec"},  32'(bus.sec),  32'(s));
    endtask

    task automatic load(input int h, input int m, input int s);
        bus.set_valid = 1'b1;
        bus.set_hour  = 5'(h);
        bus.set_min   = 6'(m);
        bus.set_sec   = 6'(s);
        tick(1);
        bus.set_valid = 1'b0;
    endtask

    // Rising edge on usr_clk: tick expected exactly three clk edges later, then usr_clk drops.
    task automatic usr_edge(input string tag, input logic exp_tick);
        bus.usr_clk = 1'b1;
        tick(2);
        chk({tag, ".early"}, 32'(bus.sec_tick), 32'd0);
        tick(1);
        chk({tag, ".tick"}, 32'(bus.sec_tick), 32'(exp_tick));
        bus.usr_clk = 1'b0;
        tick(4);
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        reset         = 1'b0;
        bus.usr_clk   = 1'b0;
        bus.run       = 1'b0;
        bus.set_valid = 1'b0;
        bus.set_hour  = '0;
        bus.set_min   = '0;
        bus.set_sec   = '0;
`ifdef RTC_ALARM_EN
        bus.alarm_hour = '0;
        bus.alarm_min  = '0;
        bus.alarm_arm  = 1'b0;
`endif
        tick(2);
        chk_time("rst", 0, 0, 0);
        chk("rst.set_ready", 32'(bus.set_ready), 32'd0);
        chk("rst.sec_tick", 32'(bus.sec_tick), 32'd0);
        chk("rst.day_wrap", 32'(bus.day_wrap), 32'd0);
        chk("rst.set_err", 32'(bus.set_err), 32'd0);

        reset   = 1'b1;
        bus.run = 1'b1;
        tick(1);
        chk("run.set_ready", 32'(bus.set_ready), 32'd1);
        tick(1);

        usr_edge("e1", 1'b1);
        usr_edge("e2", 1'b1);
        usr_edge("e3", 1'b1);
        chk_time("count3", 0, 0, 3);

        load(23, 59, 59);
        chk_time("ld235959", 23, 59, 59);
        chk("ld.set_ready_low", 32'(bus.set_ready), 32'd0);
        tick(1);
        chk("ld.set_ready_back", 32'(bus.set_ready), 32'd1);
        bus.usr_clk = 1'b1;
        tick(3);
        chk("wrap.tick", 32'(bus.sec_tick), 32'd1);
        chk("wrap.day_wrap", 32'(bus.day_wrap), 32'd1);
        chk_time("wrap", 0, 0, 0);
        bus.usr_clk = 1'b0;
        tick(1);
        chk("wrap.day_wrap_off", 32'(bus.day_wrap), 32'd0);
        tick(3);

        load(24, 0, 0);
        chk("bad.set_err", 32'(bus.set_err), 32'd1);
        chk("bad.set_ready", 32'(bus.set_ready), 32'd1);
        chk_time("bad", 0, 0, 0);
        tick(1);
        chk("bad.set_err_off", 32'(bus.set_err), 32'd0);

        load(1, 59, 59);
        tick(1);
        usr_edge("hrcarry", 1'b1);
        chk_time("hrcarry", 2, 0, 0);
        chk("hrcarry.no_wrap", 32'(bus.day_wrap), 32'd0);

        bus.run = 1'b0;
        tick(1);
        usr_edge("stop1", 1'b0);
        bus.usr_clk = 1'b1;
        tick(3);
        chk("stop2.tick", 32'(bus.sec_tick), 32'd0);
        bus.run = 1'b1;
        tick(1);
        chk("resume.t1", 32'(bus.sec_tick), 32'd0);
        tick(1);
        chk("resume.t2", 32'(bus.sec_tick), 32'd0);
        chk_time("resume", 2, 0, 0);

        bus.usr_clk = 1'b0;
        tick(4);
        bus.usr_clk = 1'b1;
        tick(2);
        load(10, 0, 0);
        chk_time("align", 10, 0, 0);
        chk("align.tick", 32'(bus.sec_tick), 32'd0);
        tick(1);
        chk("align.tick2", 32'(bus.sec_tick), 32'd0);
        chk_time("align2", 10, 0, 0);

        bus.usr_clk = 1'b0;
        tick(4);
        bus.usr_clk = 1'b1;
        tick(1);
        load(10, 0, 0);
        chk_time("inload", 10, 0, 0);
        tick(1);
        chk_time("pend", 10, 0, 1);
        chk("pend.tick", 32'(bus.sec_tick), 32'd1);
        bus.usr_clk = 1'b0;
        tick(4);

`ifdef RTC_ALARM_EN
        bus.alarm_hour = 5'd7;
        bus.alarm_min  = 6'd30;
        bus.alarm_arm  = 1'b1;
        load(7, 29, 59);
        tick(1);
        chk("alarm.idle", 32'(bus.alarm), 32'd0);
        usr_edge("alarm.e", 1'b1);
        chk("alarm.set", 32'(bus.alarm), 32'd1);
        usr_edge("alarm.e2", 1'b1);
        chk("alarm.hold", 32'(bus.alarm), 32'd1);
        bus.alarm_arm = 1'b0;
        tick(1);
        chk("alarm.clear", 32'(bus.alarm), 32'd0);
`endif

        load(12, 34, 55);
        tick(1);
        usr_edge("pre_rst", 1'b1);
        chk_time("pre_rst", 12, 34, 56);
        bus.run = 1'b0;
        reset   = 1'b0;
        tick(1);
        chk_time("midrst", 0, 0, 0);
        chk("midrst.set_ready", 32'(bus.set_ready), 32'd0);
        chk("midrst.sec_tick", 32'(bus.sec_tick), 32'd0);
        reset = 1'b1;
        tick(1);
        usr_edge("post_rst_stop", 1'b0);
        chk_time("post_rst", 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
